// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port data memory between the pipeline memory stage (CPU
// port) and a DMA/debug port. The CPU normally has priority. A starvation
// counter forces the DMA to win once STARVE_LIMIT CPU accesses have completed
// while the DMA was waiting. Accesses that need more than one cycle are
// sequenced by a down-counter. Nothing can preempt an access once it has
// started.
//
// Parameters
//   WAIT_CYCLES   memory access latency in cycles (1..15)
//   STARVE_LIMIT  CPU completions tolerated while DMA waits (1..15)
//
// Ports
//   clk, rst            clock (rising edge), async active-low reset
//   cpu_req/we/addr/wdata   memory-stage access request
//   cpu_rdata           load data, valid in the CPU completion cycle
//   cpu_stall           holds the pipeline until the CPU access completes
//   dma_req/we/addr/wdata   DMA request, held stable until dma_ack
//   dma_ack, dma_rdata  one-cycle completion strobe and its read data
//   mem_en/we/addr/wdata    data memory drive
//   mem_rdata           combinational read data from the data memory
//
// FSM states
//   state        | meaning
//   -------------+------------------------------------------------------------
//   ST_IDLE      | no access latched; arbitrate combinationally and start one
//   ST_BUSY_CPU  | CPU access in flight, cnt_q = cycles left including this one
//   ST_BUSY_DMA  | DMA access in flight, cnt_q = cycles left including this one
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int WAIT_CYCLES  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,

    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_ack,
    output logic [31:0] dma_rdata,

    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY_CPU = 2'd1,
        ST_BUSY_DMA = 2'd2
    } state_t;

    // In IDLE the first access cycle is spent arbitrating. The counter
    // therefore only has to cover the remaining WAIT_CYCLES-1 cycles.
    localparam logic [3:0] CNT_LOAD     = 4'(WAIT_CYCLES - 1);
    localparam logic [3:0] STARVE_MAX   = 4'(STARVE_LIMIT);
    localparam logic [3:0] STARVE_SAT   = 4'hF;
    localparam bit         SINGLE_CYCLE = (WAIT_CYCLES == 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  starve_q, starve_d;

    logic        dma_win;
    logic        cpu_win;
    logic        owner_cpu;
    logic        owner_dma;
    logic        complete;
    logic        cpu_done;
    logic        dma_done;
    logic        owner_we;
    logic [31:0] owner_addr;
    logic [31:0] owner_wdata;

    // -------------------------------------------------------------------------
    // Arbitration, owner selection and completion detection
    // -------------------------------------------------------------------------
    always_comb begin
        dma_win   = 1'b0;
        cpu_win   = 1'b0;
        owner_cpu = 1'b0;
        owner_dma = 1'b0;
        complete  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                dma_win   = dma_req && (!cpu_req || (starve_q == STARVE_MAX));
                cpu_win   = cpu_req && !dma_win;
                owner_cpu = cpu_win;
                owner_dma = dma_win;
                complete  = SINGLE_CYCLE && (cpu_win || dma_win);
            end
            ST_BUSY_CPU: begin
                owner_cpu = 1'b1;
                complete  = (cnt_q == 4'd1);
            end
            ST_BUSY_DMA: begin
                owner_dma = 1'b1;
                complete  = (cnt_q == 4'd1);
            end
            default: begin
            end
        endcase

        cpu_done = owner_cpu && complete;
        dma_done = owner_dma && complete;
    end

    always_comb begin
        owner_we    = 1'b0;
        owner_addr  = 32'h0;
        owner_wdata = 32'h0;
        if (owner_cpu) begin
            owner_we    = cpu_we;
            owner_addr  = cpu_addr;
            owner_wdata = cpu_wdata;
        end else if (owner_dma) begin
            owner_we    = dma_we;
            owner_addr  = dma_addr;
            owner_wdata = dma_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Next state, wait-state counter and starvation counter
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (!SINGLE_CYCLE) begin
                    if (cpu_win) begin
                        state_d = ST_BUSY_CPU;
                        cnt_d   = CNT_LOAD;
                    end else if (dma_win) begin
                        state_d = ST_BUSY_DMA;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_BUSY_CPU, ST_BUSY_DMA: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // The counter only tracks CPU wins that happen while the DMA is actually
    // waiting. As soon as the DMA request drops, or the DMA gets its access,
    // the count starts over.
    always_comb begin
        starve_d = starve_q;
        if (!dma_req || dma_done) begin
            starve_d = 4'd0;
        end else if (cpu_done && (starve_q != STARVE_SAT)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: combinational, forced quiet while reset is asserted so that an
    // aborted access can never leak a write strobe.
    // -------------------------------------------------------------------------
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        cpu_stall = 1'b0;
        cpu_rdata = 32'h0;
        dma_ack   = 1'b0;
        dma_rdata = 32'h0;

        if (rst) begin
            mem_en    = owner_cpu || owner_dma;
            mem_we    = owner_we && complete;
            mem_addr  = owner_addr;
            mem_wdata = owner_wdata;
            cpu_stall = cpu_req && !cpu_done;
            cpu_rdata = cpu_done ? mem_rdata : 32'h0;
            dma_ack   = dma_done;
            dma_rdata = dma_done ? mem_rdata : 32'h0;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int NI = 4;
    // Instance k uses the 4-bit field k of each constant: W = 1,2,3,4.
    localparam logic [15:0] WC_P = {4'd4, 4'd3, 4'd2, 4'd1};
    localparam logic [15:0] SL_P = {4'd3, 4'd4, 4'd4, 4'd2};

    logic clk = 1'b0;
    logic rst;
    logic cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;

    logic [31:0] cpu_rdata [NI];
    logic [31:0] dma_rdata [NI];
    logic [31:0] mem_addr  [NI];
    logic [31:0] mem_wdata [NI];
    logic [31:0] mem_rdata [NI];
    logic [NI-1:0] cpu_stall, dma_ack, mem_en, mem_we;

    logic [31:0] mem     [NI][32];
    logic [31:0] exp_mem [NI][32];

    int checks = 0;
    int errors = 0;

    // reference model: owner 0 = none, 1 = cpu, 2 = dma; rem = cycles left
    int m_own [NI], m_rem [NI], m_starve [NI];
    int n_own [NI], n_rem [NI], n_starve [NI];
    logic        n_wr [NI];
    logic [4:0]  n_idx [NI];
    logic [31:0] n_dat [NI];
    logic        a_wr [NI];
    logic [4:0]  a_idx [NI];
    logic [31:0] a_dat [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dmem_arbiter #(
            .WAIT_CYCLES (int'(WC_P[g*4 +: 4])),
            .STARVE_LIMIT(int'(SL_P[g*4 +: 4]))
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .cpu_req  (cpu_req),
            .cpu_we   (cpu_we),
            .cpu_addr (cpu_addr),
            .cpu_wdata(cpu_wdata),
            .cpu_rdata(cpu_rdata[g]),
            .cpu_stall(cpu_stall[g]),
            .dma_req  (dma_req),
            .dma_we   (dma_we),
            .dma_addr (dma_addr),
            .dma_wdata(dma_wdata),
            .dma_ack  (dma_ack[g]),
            .dma_rdata(dma_rdata[g]),
            .mem_en   (mem_en[g]),
            .mem_we   (mem_we[g]),
            .mem_addr (mem_addr[g]),
            .mem_wdata(mem_wdata[g]),
            .mem_rdata(mem_rdata[g])
        );
        assign mem_rdata[g] = mem[g][mem_addr[g][6:2]];
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h at %0t", nm, k, act, exp, $time);
        end
    endtask

    // Applies the effects of the rising edge that just passed.
    task automatic commit();
        for (int k = 0; k < NI; k++) begin
            m_own[k]    = n_own[k];
            m_rem[k]    = n_rem[k];
            m_starve[k] = n_starve[k];
            if (n_wr[k]) exp_mem[k][n_idx[k]] = n_dat[k];
            if (a_wr[k]) mem[k][a_idx[k]] = a_dat[k];
            n_wr[k] = 1'b0;
            a_wr[k] = 1'b0;
        end
    endtask

    task automatic eval_all();
        for (int k = 0; k < NI; k++) begin
            int w, sl, win, rem;
            logic done, owe;
            logic [31:0] oa, od, rdm;
            logic e_en, e_we, e_stall, e_ack;
            logic [31:0] e_addr, e_wd, e_crd, e_drd;
            w  = int'(WC_P[k*4 +: 4]);
            sl = int'(SL_P[k*4 +: 4]);
            e_en = 0; e_we = 0; e_stall = 0; e_ack = 0;
            e_addr = 0; e_wd = 0; e_crd = 0; e_drd = 0;
            n_wr[k] = 1'b0;
            if (!rst) begin
                n_own[k] = 0; n_rem[k] = 0; n_starve[k] = 0;
            end else begin
                if (m_own[k] == 0) begin
                    if (dma_req && (!cpu_req || m_starve[k] == sl)) win = 2;
                    else if (cpu_req) win = 1;
                    else win = 0;
                    rem = w;
                end else begin
                    win = m_own[k];
                    rem = m_rem[k];
                end
                done = (win != 0) && (rem == 1);
                oa  = (win == 1) ? cpu_addr  : (win == 2) ? dma_addr  : 32'h0;
                od  = (win == 1) ? cpu_wdata : (win == 2) ? dma_wdata : 32'h0;
                owe = (win == 1) ? cpu_we    : (win == 2) ? dma_we    : 1'b0;
                rdm = exp_mem[k][oa[6:2]];
                e_en    = (win != 0);
                e_addr  = oa;
                e_wd    = od;
                e_we    = done && owe;
                e_stall = cpu_req && !(done && win == 1);
                e_crd   = (done && win == 1) ? rdm : 32'h0;
                e_ack   = done && win == 2;
                e_drd   = e_ack ? rdm : 32'h0;
                if (done || win == 0) begin
                    n_own[k] = 0; n_rem[k] = 0;
                end else begin
                    n_own[k] = win; n_rem[k] = rem - 1;
                end
                if (!dma_req || (done && win == 2)) n_starve[k] = 0;
                else if (done && win == 1 && m_starve[k] < 15) n_starve[k] = m_starve[k] + 1;
                else n_starve[k] = m_starve[k];
                if (e_we) begin
                    n_wr[k] = 1'b1; n_idx[k] = oa[6:2]; n_dat[k] = od;
                end
            end
            chk("mem_en",    k, mem_en[k],    e_en);
            chk("mem_we",    k, mem_we[k],    e_we);
            chk("mem_addr",  k, mem_addr[k],  e_addr);
            chk("mem_wdata", k, mem_wdata[k], e_wd);
            chk("cpu_stall", k, cpu_stall[k], e_stall);
            chk("cpu_rdata", k, cpu_rdata[k], e_crd);
            chk("dma_ack",   k, dma_ack[k],   e_ack);
            chk("dma_rdata", k, dma_rdata[k], e_drd);
            a_wr[k]  = mem_we[k];
            a_idx[k] = mem_addr[k][6:2];
            a_dat[k] = mem_wdata[k];
        end
    endtask

    // One clock cycle: inputs change at the falling edge, checks follow 1ns later.
    task automatic cycle(input logic r, input logic c_req, input logic c_we,
                         input logic [31:0] c_a, input logic [31:0] c_d,
                         input logic d_req, input logic d_we,
                         input logic [31:0] d_a, input logic [31:0] d_d);
        @(negedge clk);
        commit();
        rst = r;
        cpu_req = c_req; cpu_we = c_we; cpu_addr = c_a; cpu_wdata = c_d;
        dma_req = d_req; dma_we = d_we; dma_addr = d_a; dma_wdata = d_d;
        #1;
        eval_all();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    typedef struct {
        logic cr, cw; logic [31:0] ca, cd;
        logic dr, dw; logic [31:0] da, dd;
        logic en, we, stall, ack; logic [31:0] crd, drd;
    } vec_t;

    vec_t tv [9];

    logic        r_rst, r_cr, r_cw, r_dr, r_dw;
    logic [31:0] r_ca, r_cd, r_da, r_dd;

    initial begin
        rst = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        for (int k = 0; k < NI; k++) begin
            m_own[k] = 0; m_rem[k] = 0; m_starve[k] = 0;
            n_own[k] = 0; n_rem[k] = 0; n_starve[k] = 0;
            n_wr[k] = 0; a_wr[k] = 0; n_idx[k] = 0; a_idx[k] = 0; n_dat[k] = 0; a_dat[k] = 0;
            for (int i = 0; i < 32; i++) begin
                mem[k][i] = 32'h0; exp_mem[k][i] = 32'h0;
            end
            mem[k][8]  = 32'h12345678; exp_mem[k][8]  = 32'h12345678;   // 0x20
            mem[k][17] = 32'h0BADF00D; exp_mem[k][17] = 32'h0BADF00D;   // 0x44
        end

        // Single-cycle instance (W=1, starvation limit 2), one vector per cycle.
        //          cr cw  ca     cd            dr dw  da     dd            en we st ack crd           drd
        tv[0] = '{1'b0,1'b0,32'h00,32'h0,        1'b0,1'b0,32'h00,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0};
        tv[1] = '{1'b1,1'b1,32'h10,32'hDEADBEEF, 1'b0,1'b0,32'h00,32'h0,        1'b1,1'b1,1'b0,1'b0,32'h0,        32'h0};
        tv[2] = '{1'b1,1'b0,32'h10,32'h0,        1'b0,1'b0,32'h00,32'h0,        1'b1,1'b0,1'b0,1'b0,32'hDEADBEEF, 32'h0};
        tv[3] = '{1'b1,1'b0,32'h10,32'h0,        1'b1,1'b1,32'h40,32'hA5A5A5A5, 1'b1,1'b0,1'b0,1'b0,32'hDEADBEEF, 32'h0};
        tv[4] = '{1'b1,1'b0,32'h10,32'h0,        1'b1,1'b1,32'h40,32'hA5A5A5A5, 1'b1,1'b0,1'b0,1'b0,32'hDEADBEEF, 32'h0};
        tv[5] = '{1'b1,1'b0,32'h10,32'h0,        1'b1,1'b1,32'h40,32'hA5A5A5A5, 1'b1,1'b1,1'b1,1'b1,32'h0,        32'h0};
        tv[6] = '{1'b1,1'b0,32'h40,32'h0,        1'b0,1'b0,32'h00,32'h0,        1'b1,1'b0,1'b0,1'b0,32'hA5A5A5A5, 32'h0};
        tv[7] = '{1'b0,1'b0,32'h00,32'h0,        1'b1,1'b0,32'h10,32'h0,        1'b1,1'b0,1'b0,1'b1,32'h0,        32'hDEADBEEF};
        tv[8] = '{1'b0,1'b0,32'h00,32'h0,        1'b0,1'b0,32'h00,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0};

        // Reset held: requests present but every output must stay 0.
        repeat (2) cycle(1'b0, 1'b1, 1'b1, 32'h10, 32'h1, 1'b1, 1'b1, 32'h40, 32'h2);
        chk("rst_mem_en", 0, {28'h0, mem_en}, 32'h0);
        chk("rst_stall",  0, {28'h0, cpu_stall}, 32'h0);
        idle(2);

        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, tv[i].cr, tv[i].cw, tv[i].ca, tv[i].cd, tv[i].dr, tv[i].dw, tv[i].da, tv[i].dd);
            chk("tv_en",    i, mem_en[0],    tv[i].en);
            chk("tv_we",    i, mem_we[0],    tv[i].we);
            chk("tv_stall", i, cpu_stall[0], tv[i].stall);
            chk("tv_ack",   i, dma_ack[0],   tv[i].ack);
            chk("tv_crd",   i, cpu_rdata[0], tv[i].crd);
            chk("tv_drd",   i, dma_rdata[0], tv[i].drd);
        end
        idle(4);

        // W=3: load from 0x20 stalls two cycles, data in the third.
        cycle(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("w3_stall_c1", 2, cpu_stall[2], 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("w3_stall_c2", 2, cpu_stall[2], 1'b1);
        chk("w3_rdata_c2", 2, cpu_rdata[2], 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("w3_stall_c3", 2, cpu_stall[2], 1'b0);
        chk("w3_rdata_c3", 2, cpu_rdata[2], 32'h12345678);
        idle(1);
        chk("w3_idle_en", 2, mem_en[2], 1'b0);
        idle(4);

        // W=2: simultaneous requests, CPU first, DMA ack two cycles later.
        cycle(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0);
        chk("w2_cpu_first_addr", 1, mem_addr[1], 32'h20);
        chk("w2_stall_c1", 1, cpu_stall[1], 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0);
        chk("w2_stall_c2", 1, cpu_stall[1], 1'b0);
        chk("w2_crd_c2",   1, cpu_rdata[1], 32'h12345678);
        chk("w2_ack_c2",   1, dma_ack[1], 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0);
        chk("w2_dma_addr", 1, mem_addr[1], 32'h44);
        chk("w2_ack_c3",   1, dma_ack[1], 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0);
        chk("w2_ack_c4",   1, dma_ack[1], 1'b1);
        chk("w2_drd_c4",   1, dma_rdata[1], 32'h0BADF00D);
        chk("w2_stall_c4", 1, cpu_stall[1], 1'b0);
        idle(1);
        chk("w2_ack_after", 1, dma_ack[1], 1'b0);
        chk("w2_drd_after", 1, dma_rdata[1], 32'h0);
        idle(4);

        // W=4: DMA write aborted by reset at cnt == 2.
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h48, 32'h11111111);
        chk("w4_we_c1", 3, mem_we[3], 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h48, 32'h11111111);
        chk("w4_we_c2", 3, mem_we[3], 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h48, 32'h11111111);
        chk("w4_we_rst", 3, mem_we[3], 1'b0);
        chk("w4_en_rst", 3, mem_en[3], 1'b0);
        idle(3);
        chk("w4_en_after", 3, mem_en[3], 1'b0);
        chk("w4_ack_after", 3, dma_ack[3], 1'b0);
        chk("w4_mem_0x48", 3, mem[3][18], 32'h0);

        // Randomised traffic against the reference model.
        r_dr = 0; r_dw = 0; r_da = 0; r_dd = 0;
        for (int n = 0; n < 3000; n++) begin
            r_rst = ($urandom_range(0, 99) >= 2);
            r_cr  = ($urandom_range(0, 99) < 55);
            r_cw  = 1'($urandom_range(0, 1));
            r_ca  = {25'h0, 5'($urandom_range(0, 31)), 2'b00};
            r_cd  = $urandom;
            if (!(r_dr && $urandom_range(0, 9) < 8)) begin
                r_dr = ($urandom_range(0, 99) < 45);
                r_dw = 1'($urandom_range(0, 1));
                r_da = {25'h0, 5'($urandom_range(0, 31)), 2'b00};
                r_dd = $urandom;
            end
            cycle(r_rst, r_cr, r_cw, r_ca, r_cd, r_dr, r_dw, r_da, r_dd);
        end
        idle(5);
        @(negedge clk);
        commit();

        for (int k = 0; k < NI; k++)
            for (int i = 0; i < 32; i++)
                chk("mem_final", k * 32 + i, mem[k][i], exp_mem[k][i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
